// File: rtl/jesd204b_pkg.sv
// Shared constants and types for the JESD204B transmit link controller:
// control characters, ILAS geometry and the link_state encoding.
package jesd204b_pkg;

  localparam logic [7:0] K_R = 8'h1C;
  localparam logic [7:0] K_A = 8'h7C;
  localparam logic [7:0] K_Q = 8'h9C;
  localparam logic [7:0] K_K = 8'hBC;
  localparam logic [7:0] K_F = 8'hFC;

  localparam int ILAS_MULTIFRAMES = 4;
  localparam int ILAS_CFG_OCTETS  = 14;

  typedef enum logic [1:0] {
    LINK_CGS  = 2'd0,
    LINK_ILAS = 2'd1,
    LINK_DATA = 2'd2
  } link_state_t;

endpackage

// File: rtl/jesd204b_tx_link_ctrl_if.sv
// Lane-side bundle of the transmit link controller: SYNC~, scrambled data and
// link config in; encoder octets, K flags and LMFC/status out.
interface jesd204b_tx_link_ctrl_if
  import jesd204b_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic                           sync_n;
  logic [DATA_WIDTH-1:0]          tx_data;
  logic [8*ILAS_CFG_OCTETS-1:0]   ilas_cfg;
  logic [DATA_WIDTH-1:0]          tx_out;
  logic [DATA_WIDTH/8-1:0]        tx_charisk;
  logic                           data_ready;
  logic                           lmfc_pulse;
  logic [1:0]                     link_state;

  modport master (
    input  sync_n, tx_data, ilas_cfg,
    output tx_out, tx_charisk, data_ready, lmfc_pulse, link_state
  );

  modport slave (
    output sync_n, tx_data, ilas_cfg,
    input  tx_out, tx_charisk, data_ready, lmfc_pulse, link_state
  );

endinterface

// File: rtl/jesd204b_ilas_gen.sv
// Combinational ILAS word builder: maps multiframe index and word index within
// the multiframe to the ILAS octets (MSB octet first) and their K flags.
module jesd204b_ilas_gen
  import jesd204b_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 32,
  parameter int CW         = 5
) (
  input  logic [1:0]                   mf,
  input  logic [CW-1:0]                word_idx,
  input  logic [8*ILAS_CFG_OCTETS-1:0] ilas_cfg,
  output logic [DATA_WIDTH-1:0]        ilas_word,
  output logic [DATA_WIDTH/8-1:0]      ilas_charisk
);

  localparam int F = DATA_WIDTH / 8;

  int         oct_idx_s;
  logic [7:0] oct_s;
  logic       k_s;

  // Build the word octet by octet, shifting each new octet in from the right
  always_comb begin
    ilas_word    = '0;
    ilas_charisk = '0;
    oct_idx_s    = 0;
    oct_s        = 8'h00;
    k_s          = 1'b0;
    for (int j = 0; j < F; j++) begin
      oct_idx_s = int'(word_idx) * F + j;
      if (oct_idx_s == 0) begin
        oct_s = K_R;
        k_s   = 1'b1;
      end else if (oct_idx_s == F * K - 1) begin
        oct_s = K_A;
        k_s   = 1'b1;
      end else if ((mf == 2'd1) && (oct_idx_s == 1)) begin
        oct_s = K_Q;
        k_s   = 1'b1;
      end else if ((mf == 2'd1) && (oct_idx_s >= 2) && (oct_idx_s <= ILAS_CFG_OCTETS + 1)) begin
        // cfg octet 0 sits in the top byte, so octet n is found 13-n bytes up
        oct_s = 8'(ilas_cfg >> (8 * (ILAS_CFG_OCTETS + 1 - oct_idx_s)));
        k_s   = 1'b0;
      end else begin
        oct_s = 8'(oct_idx_s);
        k_s   = 1'b0;
      end
      ilas_word    = (ilas_word << 32'd8) | DATA_WIDTH'(oct_s);
      ilas_charisk = (ilas_charisk << 32'd1) | F'(k_s);
    end
  end

endmodule

// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B transmit data-link-layer controller for one lane: CGS / ILAS / DATA
// sequencing on SYNC~, free-running LMFC and scrambled-mode alignment flags.
module jesd204b_tx_link_ctrl
  import jesd204b_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int K                = 32,
  parameter int SYNC_LOSS_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  jesd204b_tx_link_ctrl_if.master  bus
);

  localparam int F  = DATA_WIDTH / 8;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int RW = $clog2(SYNC_LOSS_CYCLES + 1);
  localparam logic [CW-1:0] LMFC_LAST = CW'(K - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(SYNC_LOSS_CYCLES - 1);
  localparam logic [1:0]    MF_LAST   = 2'(ILAS_MULTIFRAMES - 1);

  // lmfc_cnt_r / state_r describe the word that the next edge will emit
  link_state_t           state_r, next_state_s, emit_state_s, link_state_r;
  logic [CW-1:0]         lmfc_cnt_r, lmfc_next_s;
  logic [1:0]            ilas_mf_r, ilas_mf_next_s;
  logic [RW-1:0]         run_r, run_next_s;
  logic                  in_link_s, loss_s, repl_s;
  logic [DATA_WIDTH-1:0] ilas_word_s, word_s, tx_out_r;
  logic [F-1:0]          ilas_isk_s, isk_s, charisk_r;
  logic                  data_ready_r, lmfc_pulse_r;

  jesd204b_ilas_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .K          (K),
    .CW         (CW)
  ) u_ilas_gen (
    .mf           (ilas_mf_r),
    .word_idx     (lmfc_cnt_r),
    .ilas_cfg     (bus.ilas_cfg),
    .ilas_word    (ilas_word_s),
    .ilas_charisk (ilas_isk_s)
  );

  // Next-state, sync-loss detection and the word to emit at the next edge
  always_comb begin
    in_link_s      = (state_r == LINK_ILAS) || (state_r == LINK_DATA);
    loss_s         = in_link_s && !bus.sync_n && (run_r == RUN_LAST);
    next_state_s   = state_r;
    emit_state_s   = state_r;
    ilas_mf_next_s = 2'd0;
    word_s         = '0;
    isk_s          = '0;
    repl_s         = 1'b0;

    if (lmfc_cnt_r == LMFC_LAST) begin
      lmfc_next_s = '0;
    end else begin
      lmfc_next_s = lmfc_cnt_r + CW'(1);
    end

    if (!in_link_s || bus.sync_n || loss_s) begin
      run_next_s = '0;
    end else begin
      run_next_s = run_r + RW'(1);
    end

    case (state_r)
      LINK_CGS: begin
        if (bus.sync_n && (lmfc_cnt_r == LMFC_LAST)) begin
          next_state_s = LINK_ILAS;
        end else begin
          next_state_s = LINK_CGS;
        end
      end
      LINK_ILAS: begin
        if (loss_s) begin
          next_state_s = LINK_CGS;
        end else if ((lmfc_cnt_r == LMFC_LAST) && (ilas_mf_r == MF_LAST)) begin
          next_state_s = LINK_DATA;
        end else begin
          next_state_s = LINK_ILAS;
        end
      end
      LINK_DATA: begin
        if (loss_s) begin
          next_state_s = LINK_CGS;
        end else begin
          next_state_s = LINK_DATA;
        end
      end
      default: next_state_s = LINK_CGS;
    endcase

    if (loss_s) begin
      emit_state_s = LINK_CGS;
    end else begin
      emit_state_s = state_r;
    end

    if ((state_r == LINK_ILAS) && (next_state_s == LINK_ILAS)) begin
      if (lmfc_cnt_r == LMFC_LAST) begin
        ilas_mf_next_s = ilas_mf_r + 2'd1;
      end else begin
        ilas_mf_next_s = ilas_mf_r;
      end
    end else begin
      ilas_mf_next_s = 2'd0;
    end

    // Scrambled-mode replacement only ever flags the last octet of the frame
    if ((lmfc_cnt_r == LMFC_LAST) && (bus.tx_data[7:0] == K_A)) begin
      repl_s = 1'b1;
    end else if (bus.tx_data[7:0] == K_F) begin
      repl_s = 1'b1;
    end else begin
      repl_s = 1'b0;
    end

    case (emit_state_s)
      LINK_CGS: begin
        word_s = {F{K_K}};
        isk_s  = '1;
      end
      LINK_ILAS: begin
        word_s = ilas_word_s;
        isk_s  = ilas_isk_s;
      end
      LINK_DATA: begin
        word_s = bus.tx_data;
        isk_s  = F'(repl_s);
      end
      default: begin
        word_s = '0;
        isk_s  = '0;
      end
    endcase
  end

  // State, counters and registered lane outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= LINK_CGS;
      link_state_r <= LINK_CGS;
      lmfc_cnt_r   <= '0;
      ilas_mf_r    <= 2'd0;
      run_r        <= '0;
      tx_out_r     <= '0;
      charisk_r    <= '0;
      data_ready_r <= 1'b0;
      lmfc_pulse_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      link_state_r <= emit_state_s;
      lmfc_cnt_r   <= lmfc_next_s;
      ilas_mf_r    <= ilas_mf_next_s;
      run_r        <= run_next_s;
      tx_out_r     <= word_s;
      charisk_r    <= isk_s;
      data_ready_r <= (next_state_s == LINK_DATA);
      lmfc_pulse_r <= (lmfc_cnt_r == '0);
    end
  end

  assign bus.tx_out     = tx_out_r;
  assign bus.tx_charisk = charisk_r;
  assign bus.data_ready = data_ready_r;
  assign bus.lmfc_pulse = lmfc_pulse_r;
  assign bus.link_state = link_state_r;

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// Directed bench for jesd204b_tx_link_ctrl with K=8, F=4: a vector table for
// the ILAS and DATA phases plus hand sequences for sync loss and reset.
module tb_jesd204b_tx_link_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  jesd204b_tx_link_ctrl_if #(.DATA_WIDTH(32)) bus_if ();

  jesd204b_tx_link_ctrl #(
    .DATA_WIDTH       (32),
    .K                (8),
    .SYNC_LOSS_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tx_data;
    logic [31:0] exp_out;
    logic [3:0]  exp_isk;
    logic        exp_ready;
    logic        exp_pulse;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t        vecs [48];
  logic [31:0] dvals [16];
  logic [15:0] dkbits;

  localparam logic [31:0] CGS_WORD = 32'hBCBCBCBC;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] out, input logic [3:0] isk,
                          input logic ready, input logic pulse, input logic [1:0] st);
    chk({tag, " tx_out"}, bus_if.tx_out, out);
    chk({tag, " charisk"}, 32'(bus_if.tx_charisk), 32'(isk));
    chk({tag, " data_ready"}, 32'(bus_if.data_ready), 32'(ready));
    chk({tag, " lmfc_pulse"}, 32'(bus_if.lmfc_pulse), 32'(pulse));
    chk({tag, " link_state"}, 32'(bus_if.link_state), 32'(st));
  endtask

  initial begin
    int b;
    n_checks = 0;
    n_fail   = 0;

    // ILAS table: default D octets = o, then hand-set control and cfg words
    for (int w = 0; w < 32; w++) begin
      b = (w % 8) * 4;
      vecs[w].tx_data   = 32'h0;
      vecs[w].exp_out   = {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
      vecs[w].exp_isk   = 4'h0;
      vecs[w].exp_ready = (w == 31);
      vecs[w].exp_pulse = ((w % 8) == 0);
      vecs[w].exp_state = 2'd1;
      if ((w % 8) == 0) begin
        vecs[w].exp_out[31:24] = 8'h1C;
        vecs[w].exp_isk        = 4'h8;
      end
      if ((w % 8) == 7) begin
        vecs[w].exp_out[7:0] = 8'h7C;
        vecs[w].exp_isk      = 4'h1;
      end
    end
    vecs[8].exp_out  = 32'h1C9CA0A1;
    vecs[8].exp_isk  = 4'hC;
    vecs[9].exp_out  = 32'hA2A3A4A5;
    vecs[10].exp_out = 32'hA6A7A8A9;
    vecs[11].exp_out = 32'hAAABACAD;

    // DATA table: lmfc_cnt of entry d is d%8
    dvals = '{32'h12345678, 32'hA5A5A5A5, 32'hFC000000, 32'h0000007C,
              32'h7C7C7C7C, 32'hFFFFFFFC, 32'h0BC0FC00, 32'h0000007C,
              32'h000000FC, 32'h0000007C, 32'hDEADBEEF, 32'h000000FC,
              32'hFC7C7CFC, 32'h00000000, 32'h0000007D, 32'h000000FC};
    dkbits = 16'h99A0;
    for (int d = 0; d < 16; d++) begin
      vecs[32 + d].tx_data   = dvals[d];
      vecs[32 + d].exp_out   = dvals[d];
      vecs[32 + d].exp_isk   = {3'b000, dkbits[d]};
      vecs[32 + d].exp_ready = 1'b1;
      vecs[32 + d].exp_pulse = ((d % 8) == 0);
      vecs[32 + d].exp_state = 2'd2;
    end

    // Reset with sync_n low
    reset           = 1'b1;
    bus_if.sync_n   = 1'b0;
    bus_if.tx_data  = 32'h0;
    bus_if.ilas_cfg = 112'hA0A1A2A3A4A5A6A7A8A9AAABACAD;
    step();
    step();
    chk_word("reset", 32'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;

    // CGS holds; lmfc_pulse every 8 words starting with the first
    for (int k = 0; k < 20; k++) begin
      step();
      chk_word($sformatf("cgs%0d", k), CGS_WORD, 4'hF, 1'b0, ((k % 8) == 0), 2'd0);
    end

    // tx_out shows lmfc_cnt=3: raise sync_n, ILAS waits for the boundary
    bus_if.sync_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_word($sformatf("hs_wait%0d", k), CGS_WORD, 4'hF, 1'b0, 1'b0, 2'd0);
    end

    for (int i = 0; i < 48; i++) begin
      bus_if.tx_data = vecs[i].tx_data;
      step();
      chk_word($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_isk,
               vecs[i].exp_ready, vecs[i].exp_pulse, vecs[i].exp_state);
    end

    // Sync loss: 3 lows ignored, high clears, then 4 lows drop the link
    bus_if.sync_n = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) bus_if.sync_n = 1'b1;
      else        bus_if.sync_n = 1'b0;
      bus_if.tx_data = {16'hD000, 8'(k), 8'h11};
      step();
      chk_word($sformatf("err%0d", k), {16'hD000, 8'(k), 8'h11}, 4'h0, 1'b1, (k == 0), 2'd2);
    end
    bus_if.sync_n  = 1'b0;
    bus_if.tx_data = 32'h55667788;
    step();
    chk_word("loss", CGS_WORD, 4'hF, 1'b0, 1'b0, 2'd0);

    // Re-sync: high first sampled at lmfc_cnt=0 edge, so one full multiframe of CGS
    bus_if.sync_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_word($sformatf("resync%0d", k), CGS_WORD, 4'hF, 1'b0, (k == 0), 2'd0);
    end
    step();
    chk_word("resync_ilas0", 32'h1C010203, 4'h8, 1'b0, 1'b1, 2'd1);
    step();
    chk_word("resync_ilas1", 32'h04050607, 4'h0, 1'b0, 1'b0, 2'd1);
    step();

    // Reset for one cycle mid-ILAS
    reset = 1'b1;
    step();
    chk_word("midreset", 32'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_word($sformatf("post_rst%0d", k), CGS_WORD, 4'hF, 1'b0, (k == 0), 2'd0);
    end
    step();
    chk_word("post_rst_ilas0", 32'h1C010203, 4'h8, 1'b0, 1'b1, 2'd1);
    for (int k = 1; k < 28; k++) begin
      step();
      chk($sformatf("post_rst_ilas%0d state", k), 32'(bus_if.link_state), 32'd1);
    end

    // Sync-loss threshold lands on the last ILAS word: CGS wins over DATA
    bus_if.sync_n = 1'b0;
    step();
    step();
    step();
    chk_word("ilas30", 32'h18191A1B, 4'h0, 1'b0, 1'b0, 2'd1);
    step();
    chk_word("loss_vs_data", CGS_WORD, 4'hF, 1'b0, 1'b0, 2'd0);
    bus_if.sync_n = 1'b1;
    step();
    chk_word("loss_vs_data_after", CGS_WORD, 4'hF, 1'b0, 1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
